// File: rtl/pk_readout_pkg.sv
// Shared types and size derivations for the matrix readout path.
`ifndef PK_READOUT_DEFS_SV
`include "pk_readout_defs.sv"
`endif

package pk_readout_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } pk_state_e;

    function automatic int pk_depth(input int rows, input int cols, input int word_bits);
        return (rows * cols) / word_bits;
    endfunction

    // Clamped to 1 so a single-word matrix still gets a legal address port.
    function automatic int pk_aw(input int depth);
        return (depth > 1) ? `CLOG2(depth) : 1;
    endfunction

endpackage

// File: rtl/pk_readout_defs.sv
// Common macros shared by the readout blocks.
`ifndef PK_READOUT_DEFS_SV
`define PK_READOUT_DEFS_SV
`define CLOG2(x) $clog2(x)
`endif

// File: rtl/pk_readout_fifo.sv
// Two-entry skid FIFO between the matrix memory and the stream port.
module readout_fifo #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = push_data_i;
                else               e1_d = push_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            // Simultaneous push/pop: head advances, occupancy unchanged.
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    e0_d = e1_q;
                    e1_d = push_data_i;
                end else begin
                    e0_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/pk_readout.sv
// Streams the systemized matrix out of memory once the systemizer reports success.
// state  | meaning
// IDLE   | waiting for sys_done; failure latches err
// STREAM | issuing reads while FIFO + in-flight leaves room
// DRAIN  | all reads issued; waiting for the last-word handshake
module pk_readout
    import pk_readout_pkg::*;
#(
    parameter  int N     = 20,
    parameter  int M     = 1,
    parameter  int L     = 200,
    parameter  int K     = 400,
    localparam int DEPTH = pk_depth(L, K, N),
    localparam int AW    = pk_aw(DEPTH),
    localparam int W     = N * M
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sys_done,
    input  logic          sys_fail,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  data_out,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [W-1:0]  m_data,
    output logic          m_last,
    output logic          busy,
    output logic          err,
    output logic          done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    pk_state_e     state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          inflight_q, inflight_last_q;
    logic          pop, at_last;
    logic [1:0]    fifo_count;
    logic [W:0]    fifo_head;
    logic [2:0]    occupancy;

    readout_fifo #(.W(W + 1)) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, data_out}),
        .pop_i       (pop),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign m_valid   = (fifo_count != 2'd0);
    assign m_data    = fifo_head[W-1:0];
    assign m_last    = m_valid & fifo_head[W];
    assign pop       = m_valid & m_ready;
    assign at_last   = (addr_q == LAST_ADDR);
    // Slots that will still be committed after this cycle's pop.
    assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sys_done) begin
                    if (sys_fail) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = '0;
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (occupancy < 3'd2) begin
                    rd_en = 1'b1;
                    if (at_last) state_d = DRAIN;
                    else         addr_d  = addr_q + AW'(1);
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            err_q           <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            err_q           <= err_d;
            done_q          <= done_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en & at_last;
        end
    end

    assign rd_addr = addr_q;
    assign busy    = (state_q != IDLE);
    assign err     = err_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pk_readout.sv
// Self-checking bench for pk_readout against a transaction-count reference model.
module tb_pk_readout;

    localparam int N     = 4;
    localparam int M     = 1;
    localparam int L     = 8;
    localparam int K     = 16;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int W     = N * M;

    logic          clk = 1'b0;
    logic          rst;
    logic          sys_done;
    logic          sys_fail;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  data_out;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic          m_last;
    logic          busy;
    logic          err;
    logic          done;

    int checks = 0;
    int errors = 0;

    pk_readout #(.N(N), .M(M), .L(L), .K(K)) dut (
        .clk      (clk),
        .rst      (rst),
        .sys_done (sys_done),
        .sys_fail (sys_fail),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .data_out (data_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy),
        .err      (err),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Matrix memory: word at address a holds a (truncated to the word width).
    always @(posedge clk) begin
        if (rd_en) data_out <= rd_addr[W-1:0];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One sys_done-started stream. Cycle 0 carries sys_done. The model only
    // counts reads issued and words handshaken; a read's data becomes visible
    // two cycles later. abort_at >= 0 returns once that many words were taken.
    task automatic run_stream(input bit rnd, input int hold_low, input bit extra_done,
                              input int abort_at);
        int  reads, pops, r1, r2, last_hs;
        bit  exp_valid, pop_now, exp_rd, prev_stall, finished;
        logic [W-1:0] prev_data;
        reads = 0; pops = 0; r1 = 0; r2 = 0; last_hs = -1;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 400; c++) begin
            if (abort_at >= 0 && pops == abort_at) return;
            sys_done = (c == 0) || (extra_done && c == 5);
            sys_fail = extra_done && c == 5;
            if (c >= 1 && c <= hold_low) m_ready = 1'b0;
            else if (rnd)                m_ready = 1'($urandom_range(0, 1));
            else                         m_ready = 1'b1;
            @(negedge clk);
            finished  = (last_hs >= 0);
            exp_valid = (r2 > pops);
            pop_now   = exp_valid && m_ready;
            exp_rd    = (c >= 1) && (reads < DEPTH) && ((reads - pops - int'(pop_now)) < 2);
            chk("m_valid", m_valid, exp_valid);
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd && rd_en) chk("rd_addr", rd_addr, reads);
            if (exp_valid) begin
                chk("m_data", m_data, pops % 16);
                chk("m_last", m_last, pops == DEPTH - 1);
            end else begin
                chk("m_last_idle", m_last, 0);
            end
            if (prev_stall) chk("m_data_stable", m_data, prev_data);
            if (c >= 1) begin
                chk("busy", busy, !finished);
                chk("err_clear", err, 0);
                chk("done", done, finished && c == last_hs + 1);
            end
            if (hold_low > 0 && c == hold_low) chk("stall_reads", reads, 2);
            if (exp_rd) reads++;
            if (pop_now) begin
                pops++;
                if (pops == DEPTH) last_hs = c;
            end
            prev_stall = exp_valid && !m_ready;
            prev_data  = m_data;
            r2 = r1;
            r1 = reads;
            @(posedge clk);
            #1;
            if (finished && c == last_hs + 1) break;
        end
        sys_done = 1'b0;
        sys_fail = 1'b0;
        if (abort_at < 0) begin
            chk("stream_words", pops, DEPTH);
            chk("stream_reads", reads, DEPTH);
            if (!rnd && hold_low == 0) chk("last_handshake_cycle", last_hs, 34);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_last"}, m_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        rst      = 1'b0;
        sys_done = 1'b0;
        sys_fail = 1'b0;
        m_ready  = 1'b0;

        @(negedge clk);
        check_quiet("reset");
        chk("reset_err", err, 0);
        chk("reset_rd_addr", rd_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back stream with consumer always ready.
        run_stream(1'b0, 0, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;

        // Systemizer failure: err latches, nothing is read.
        sys_done = 1'b1;
        sys_fail = 1'b1;
        @(posedge clk);
        #1;
        sys_done = 1'b0;
        sys_fail = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("fail_err", err, 1);
            chk("fail_rd_en", rd_en, 0);
            chk("fail_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        // Good sys_done clears err and streams fully.
        run_stream(1'b0, 0, 1'b0, -1);

        // Random backpressure.
        run_stream(1'b1, 0, 1'b0, -1);
        run_stream(1'b1, 0, 1'b0, -1);

        // Consumer stalled for 10 cycles after start.
        run_stream(1'b0, 10, 1'b0, -1);

        // A second (failing) sys_done mid-stream must be ignored.
        run_stream(1'b0, 0, 1'b1, -1);

        // Reset after 10 words: everything clears at once, restart from 0.
        run_stream(1'b0, 0, 1'b0, 10);
        rst = 1'b0;
        #1;
        check_quiet("abort");
        chk("abort_err", err, 0);
        chk("abort_rd_addr", rd_addr, 0);
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_quiet("post_abort");
            @(posedge clk);
            #1;
        end
        run_stream(1'b0, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
